// File: rtl/cache_stats_pkg.sv
// Shared definitions for the cache statistics readout path.
// Contents: readout sequencer state encoding, default header tag, and the
// controller's statistics index map (low-word index of each counter pair).
package cache_stats_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_PUSH   = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_t;

  localparam logic [7:0] HDR_TAG_DEF = 8'hC5;

  // Statistics index space of the controller (select_data_record = 2'b00).
  localparam logic [4:0] HIT_LO     = 5'd0;
  localparam logic [4:0] MISS_LO    = 5'd2;
  localparam logic [4:0] WB_LO      = 5'd4;
  localparam logic [4:0] WALL_LO    = 5'd6;
  localparam logic [4:0] EXP_LO     = 5'd8;
  localparam logic [4:0] DEF_LO     = 5'd10;
  localparam logic [4:0] MEXP_LO    = 5'd12;
  localparam logic [4:0] ID         = 5'd15;
  localparam logic [4:0] DEFMISS_LO = 5'd16;
  localparam logic [4:0] RAND_LO    = 5'd18;

endpackage

// File: rtl/cache_stats_readout_sequencer.sv
// cache_stats_readout_sequencer
//   Walks the cache performance controller's statistics indices 0..LAST_IDX
//   and streams a header word plus one word per index on a valid/ready port.
//   The header is {HDR_TAG, seq[7:0], 11'b0, LAST_IDX[4:0]}.
// Ports:
//   clock_i, reset_i (async, active high)
//   start_i      dump request          count_en_i  host counter enable
//   stat_i       controller comm_o     comm_o      controller comm_i
//   select_o     controller record select (fixed statistics bank)
//   m_data_o/m_index_o/m_valid_o/m_last_o/m_ready_i  output stream
//   busy_o, done_o (1-cycle pulse), overrun_o (sticky start-while-busy)
// Config macro: STATS_FREEZE_EN -- hold the controller's counter enable low
//   for the whole dump so every dumped counter comes from one snapshot.
module cache_stats_readout_sequencer
  import cache_stats_pkg::*;
#(
  parameter int         LAST_IDX    = 19,
  parameter int         WAIT_CYCLES = 1,
  parameter logic [7:0] HDR_TAG     = HDR_TAG_DEF
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        count_en_i,
  input  logic [31:0] stat_i,
  output logic [31:0] comm_o,
  output logic [1:0]  select_o,
  output logic [31:0] m_data_o,
  output logic [4:0]  m_index_o,
  output logic        m_valid_o,
  output logic        m_last_o,
  input  logic        m_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        overrun_o
);

  localparam logic [4:0] LAST5 = 5'(LAST_IDX);
  localparam logic [2:0] WLAST = 3'(WAIT_CYCLES - 1);

  seq_state_t  state;
  logic [4:0]  idx;
  logic [7:0]  seq;
  logic [2:0]  wcnt;
  logic        cen_q;
  logic        cen_d;
  logic        in_dump;

  // DONE is deliberately excluded: a start there is dropped silently.
  assign in_dump = (state == ST_HDR) || (state == ST_WAIT) ||
                   (state == ST_SAMPLE) || (state == ST_PUSH);

`ifdef STATS_FREEZE_EN
  // Low from the start-acceptance edge through the DONE edge.
  assign cen_d = count_en_i & ~(in_dump || (state == ST_IDLE && start_i));
`else
  assign cen_d = count_en_i;
`endif

  // idx is cleared on the way back to IDLE, so the index field reads 0 there.
  assign comm_o   = {7'b0, cen_q, 19'b0, idx};
  assign select_o = 2'b00;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= ST_IDLE;
      idx       <= '0;
      seq       <= '0;
      wcnt      <= '0;
      cen_q     <= 1'b0;
      m_data_o  <= '0;
      m_index_o <= '0;
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      cen_q  <= cen_d;
      done_o <= 1'b0;
      if (start_i && in_dump) overrun_o <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            overrun_o <= 1'b0;
            m_data_o  <= {HDR_TAG, seq, 11'b0, LAST5};
            m_index_o <= '0;
            m_last_o  <= 1'b0;
            m_valid_o <= 1'b1;
            busy_o    <= 1'b1;
            state     <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (m_ready_i) begin
            m_valid_o <= 1'b0;
            idx       <= '0;
            wcnt      <= '0;
            state     <= ST_WAIT;
          end
        end
        // Covers the controller's register stage plus any extra settling.
        ST_WAIT: begin
          if (wcnt == WLAST) state <= ST_SAMPLE;
          else               wcnt  <= wcnt + 3'd1;
        end
        ST_SAMPLE: begin
          m_data_o  <= stat_i;
          m_index_o <= idx;
          m_last_o  <= (idx == LAST5);
          m_valid_o <= 1'b1;
          state     <= ST_PUSH;
        end
        ST_PUSH: begin
          if (m_ready_i) begin
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
            if (idx == LAST5) begin
              done_o <= 1'b1;
              state  <= ST_DONE;
            end else begin
              idx   <= idx + 5'd1;
              wcnt  <= '0;
              state <= ST_WAIT;
            end
          end
        end
        ST_DONE: begin
          busy_o <= 1'b0;
          seq    <= seq + 8'd1;
          idx    <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_stats_readout_sequencer.sv
// Directed bench for cache_stats_readout_sequencer with a one-register
// controller model that returns {27'h0, index}.
module tb_cache_stats_readout_sequencer;

  localparam int LAST = 19;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        count_en_i = 1'b1;
  logic [31:0] stat_i = '0;
  logic [31:0] comm_o;
  logic [1:0]  select_o;
  logic [31:0] m_data_o;
  logic [4:0]  m_index_o;
  logic        m_valid_o;
  logic        m_last_o;
  logic        m_ready_i = 1'b1;
  logic        busy_o;
  logic        done_o;
  logic        overrun_o;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] wd[$];
  logic [4:0]  ix[$];
  logic        lt[$];
  int          n_done;

  cache_stats_readout_sequencer dut (
    .clock_i(clk), .reset_i(rst), .start_i(start_i), .count_en_i(count_en_i),
    .stat_i(stat_i), .comm_o(comm_o), .select_o(select_o),
    .m_data_o(m_data_o), .m_index_o(m_index_o), .m_valid_o(m_valid_o),
    .m_last_o(m_last_o), .m_ready_i(m_ready_i), .busy_o(busy_o),
    .done_o(done_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  // Controller model: comm_i registered, statistics word = index.
  always @(posedge clk or posedge rst)
    if (rst) stat_i <= '0;
    else     stat_i <= {27'h0, comm_o[4:0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // rmode 0: always ready, 1: pseudo-random ready. ovr_at: cycle to pulse start.
  task automatic run_dump(input int rmode, input int ovr_at);
    int   cyc;
    bit   fin;
    bit   stall;
    bit   prev_cen;
    logic [31:0] hd;
    logic [4:0]  hi;
    logic        hl;
    wd.delete(); ix.delete(); lt.delete();
    n_done = 0;
    @(negedge clk); start_i = 1'b1;
    prev_cen = count_en_i;
    @(negedge clk); start_i = 1'b0;
    cyc = 0; fin = 0; stall = 0; hd = '0; hi = '0; hl = 1'b0;
    while (!fin && cyc < 3000) begin
      if (cyc == 0) begin
        chk("busy_on", {31'b0, busy_o}, 32'd1);
        chk("hdr_vld", {31'b0, m_valid_o}, 32'd1);
        chk("ovr_clr", {31'b0, overrun_o}, 32'd0);
      end
      m_ready_i = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (stall) begin
        chk("hold_vld", {31'b0, m_valid_o}, 32'd1);
        chk("hold_dat", m_data_o, hd);
        chk("hold_idx", {27'b0, m_index_o}, {27'b0, hi});
        chk("hold_lst", {31'b0, m_last_o}, {31'b0, hl});
      end
`ifdef STATS_FREEZE_EN
      chk("cen_frz", {31'b0, comm_o[24]}, busy_o ? 32'd0 : {31'b0, prev_cen});
`else
      chk("cen", {31'b0, comm_o[24]}, {31'b0, prev_cen});
`endif
      start_i = (cyc == ovr_at);
      if (done_o) n_done++;
      if (m_valid_o && m_ready_i) begin
        wd.push_back(m_data_o); ix.push_back(m_index_o); lt.push_back(m_last_o);
      end
      stall = m_valid_o && !m_ready_i;
      hd = m_data_o; hi = m_index_o; hl = m_last_o;
      if (n_done > 0 && !busy_o) fin = 1;
      cyc++;
      prev_cen = count_en_i;
      @(negedge clk);
    end
    start_i   = 1'b0;
    m_ready_i = 1'b1;
    if (!fin) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic check_dump(input logic [7:0] sq, input bit full);
    chk("nwords", wd.size(), LAST + 2);
    if (wd.size() == LAST + 2) begin
      chk("header", wd[0], {8'hC5, sq, 11'b0, 5'd19});
      chk("hdr_lst", {31'b0, lt[0]}, 32'd0);
      if (full) begin
        for (int i = 1; i <= LAST + 1; i++) begin
          chk("data", wd[i], i - 1);
          chk("index", {27'b0, ix[i]}, i - 1);
          chk("last", {31'b0, lt[i]}, (i == LAST + 1) ? 32'd1 : 32'd0);
        end
      end
    end
    chk("done_pulses", n_done, 1);
  endtask

  initial begin
    int cyc;
    // Reset state
    rst = 1'b1;
    #12;
    chk("rst_comm", comm_o, 32'd0);
    chk("rst_sel", {30'b0, select_o}, 32'd0);
    chk("rst_data", m_data_o, 32'd0);
    chk("rst_vld", {31'b0, m_valid_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Idle counter-enable tracking
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      count_en_i = 1'(i & 1);
      @(negedge clk);
      chk("cen_idle", {31'b0, comm_o[24]}, {31'b0, 1'(i & 1)});
    end
    count_en_i = 1'b1;
    @(negedge clk);

    // Dump 0: ready always high
    run_dump(0, -1);
    check_dump(8'd0, 1);
    chk("ovr_none", {31'b0, overrun_o}, 32'd0);
    chk("idle_idx", {27'b0, comm_o[4:0]}, 32'd0);

    // Dump 1: random backpressure
    run_dump(1, -1);
    check_dump(8'd1, 1);

    // Dump 2: start while busy
    run_dump(0, 10);
    check_dump(8'd2, 1);
    chk("ovr_set", {31'b0, overrun_o}, 32'd1);

    // Dump 3: next start clears overrun (checked at cycle 0)
    run_dump(1, -1);
    check_dump(8'd3, 1);

    // Dumps 4..255, then seq wraps to 0
    for (int d = 4; d < 256; d++) begin
      run_dump(0, -1);
      check_dump(8'(d), 0);
    end
    run_dump(0, -1);
    check_dump(8'd0, 1);

    // Reset mid-dump at data word 7
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    cyc = 0;
    while (!(m_valid_o && m_index_o == 5'd7) && cyc < 500) begin
      @(negedge clk); cyc++;
    end
    if (cyc >= 500) chk("word7_timeout", 32'd0, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", {31'b0, m_valid_o}, 32'd0);
    chk("arst_last", {31'b0, m_last_o}, 32'd0);
    chk("arst_data", m_data_o, 32'd0);
    chk("arst_idx", {27'b0, m_index_o}, 32'd0);
    chk("arst_comm", comm_o, 32'd0);
    chk("arst_busy", {31'b0, busy_o}, 32'd0);
    chk("arst_done", {31'b0, done_o}, 32'd0);
    chk("arst_ovr", {31'b0, overrun_o}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run_dump(1, -1);
    check_dump(8'd0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
